captura_resultado_red: RTL and testbench

CAPTURA_RESULTADO_RED -- requirements
Module: captura_resultado_red

---
 rtl/captura_resultado_red.sv | 120 ++++++++++++
 tb/tb_captura_resultado_red.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/captura_resultado_red.sv
// Captures each network result together with the input sample that produced it.
// Issued samples queue in a small FIFO; host-readable sticky flags report ready, error and data loss.
module captura_resultado_red #(
  parameter int Width = 24,
  parameter int Depth = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     StartIn,
  input  logic [Width-1:0]         DatoEntrada,
  input  logic                     ValidNet,
  input  logic [Width-1:0]         SalidaNet,
  input  logic                     OverflowNet,
  input  logic                     Read,
  input  logic [8:0]               Address,
  output logic [Width-1:0]         DatoSalida,
  output logic [Width-1:0]         EntradaAsociada,
  output logic                     DatoListo,
  output logic                     ErrorFlag,
  output logic                     Overrun,
  output logic [$clog2(Depth):0]   Ocupacion
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int OW = $clog2(Depth) + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(Depth);
  localparam logic [8:0] ADDR_LISTO = 9'h004;
  localparam logic [8:0] ADDR_ERROR = 9'h008;

  logic [Width-1:0] mem [Depth];

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [OW-1:0]    occ_reg, occ_next;
  logic [Width-1:0] salida_reg, salida_next;
  logic [Width-1:0] entrada_reg, entrada_next;
  logic             listo_reg, listo_next;
  logic             error_reg, error_next;
  logic             overrun_reg, overrun_next;

  logic full, empty, push, pop;
  logic clr_listo, clr_error;

  // Full/empty come from the pre-edge occupancy, so a simultaneous pop makes room for a push.
  assign full      = (occ_reg == FULL_OCC);
  assign empty     = (occ_reg == '0);
  assign push      = StartIn && (!full || ValidNet);
  assign pop       = ValidNet && !empty;
  assign clr_listo = Read && (Address == ADDR_LISTO);
  assign clr_error = Read && (Address == ADDR_ERROR);

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    occ_next     = occ_reg + OW'(push) - OW'(pop);
    salida_next  = salida_reg;
    entrada_next = entrada_reg;
    listo_next   = listo_reg && !clr_listo;
    error_next   = error_reg && !clr_error;
    overrun_next = overrun_reg && !clr_error;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (StartIn && full && !ValidNet) begin
      overrun_next = 1'b1;
    end
    if (ValidNet) begin
      salida_next = SalidaNet;
      listo_next  = 1'b1;
      if (listo_reg) begin
        overrun_next = 1'b1;
      end
      if (empty || OverflowNet) begin
        error_next = 1'b1;
      end
    end
    if (pop) begin
      entrada_next = mem[rd_ptr_reg];
      rd_ptr_next  = rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      occ_reg     <= '0;
      salida_reg  <= '0;
      entrada_reg <= '0;
      listo_reg   <= 1'b0;
      error_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      occ_reg     <= occ_next;
      salida_reg  <= salida_next;
      entrada_reg <= entrada_next;
      listo_reg   <= listo_next;
      error_reg   <= error_next;
      overrun_reg <= overrun_next;
    end
  end

  // Sample storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= DatoEntrada;
    end
  end

  assign DatoSalida      = salida_reg;
  assign EntradaAsociada = entrada_reg;
  assign DatoListo       = listo_reg;
  assign ErrorFlag       = error_reg;
  assign Overrun         = overrun_reg;
  assign Ocupacion       = occ_reg;

endmodule

// File: tb/tb_captura_resultado_red.sv
// Directed-vector bench for captura_resultado_red with hand-computed expectations.
module tb_captura_resultado_red;

  logic        CLK;
  logic        RESET_N;
  logic        StartIn;
  logic [23:0] DatoEntrada;
  logic        ValidNet;
  logic [23:0] SalidaNet;
  logic        OverflowNet;
  logic        Read;
  logic [8:0]  Address;
  logic [23:0] DatoSalida;
  logic [23:0] EntradaAsociada;
  logic        DatoListo;
  logic        ErrorFlag;
  logic        Overrun;
  logic [2:0]  Ocupacion;

  int vectors_applied = 0;
  int miscompares     = 0;

  captura_resultado_red #(.Width(24), .Depth(4)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .StartIn         (StartIn),
    .DatoEntrada     (DatoEntrada),
    .ValidNet        (ValidNet),
    .SalidaNet       (SalidaNet),
    .OverflowNet     (OverflowNet),
    .Read            (Read),
    .Address         (Address),
    .DatoSalida      (DatoSalida),
    .EntradaAsociada (EntradaAsociada),
    .DatoListo       (DatoListo),
    .ErrorFlag       (ErrorFlag),
    .Overrun         (Overrun),
    .Ocupacion       (Ocupacion)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  // One clock cycle with the given strobes; outputs are stable on return (1 time unit after the edge).
  task automatic cyc(input logic s, input logic [23:0] d, input logic v, input logic [23:0] r,
                     input logic ov, input logic rd, input logic [8:0] a);
    StartIn     = s;
    DatoEntrada = d;
    ValidNet    = v;
    SalidaNet   = r;
    OverflowNet = ov;
    Read        = rd;
    Address     = a;
    @(posedge CLK);
    #1;
    StartIn     = 1'b0;
    DatoEntrada = '0;
    ValidNet    = 1'b0;
    SalidaNet   = '0;
    OverflowNet = 1'b0;
    Read        = 1'b0;
    Address     = '0;
  endtask

  task automatic idle();
    cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 9'h0);
  endtask

  task automatic push(input logic [23:0] d);
    cyc(1'b1, d, 1'b0, 24'h0, 1'b0, 1'b0, 9'h0);
  endtask

  task automatic result(input logic [23:0] r, input logic ov);
    cyc(1'b0, 24'h0, 1'b1, r, ov, 1'b0, 9'h0);
  endtask

  task automatic host_read(input logic [8:0] a);
    cyc(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1, a);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, ".salida"},  32'(DatoSalida), 32'h0);
    check_val({tag, ".entrada"}, 32'(EntradaAsociada), 32'h0);
    check_val({tag, ".flags"},   {29'h0, DatoListo, ErrorFlag, Overrun}, 32'h0);
    check_val({tag, ".ocup"},    32'(Ocupacion), 32'h0);
  endtask

  initial begin
    RESET_N     = 1'b1;
    StartIn     = 1'b0;
    DatoEntrada = '0;
    ValidNet    = 1'b0;
    SalidaNet   = '0;
    OverflowNet = 1'b0;
    Read        = 1'b0;
    Address     = '0;
    #1 RESET_N = 1'b0;
    #1 check_cleared("reset");
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET_N = 1'b1;

    // Basic capture
    push(24'h000100);
    idle();
    idle();
    check_val("basic.ocup_pending", 32'(Ocupacion), 32'd1);
    result(24'hFFFF80, 1'b0);
    check_val("basic.listo",   32'(DatoListo), 32'd1);
    check_val("basic.salida",  32'(DatoSalida), 32'hFFFF80);
    check_val("basic.entrada", 32'(EntradaAsociada), 32'h000100);
    check_val("basic.ocup",    32'(Ocupacion), 32'd0);
    check_val("basic.err_ovr", {30'h0, ErrorFlag, Overrun}, 32'h0);
    host_read(9'h004);
    check_val("basic.listo_clr", 32'(DatoListo), 32'd0);

    // Full FIFO: fifth sample is dropped
    for (int i = 1; i <= 5; i++) push(24'(i));
    check_val("full.ocup",    32'(Ocupacion), 32'd4);
    check_val("full.overrun", 32'(Overrun), 32'd1);
    host_read(9'h008);
    check_val("full.overrun_clr", 32'(Overrun), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      result(24'(32'h10 + i), 1'b0);
      check_val($sformatf("full.entrada%0d", i), 32'(EntradaAsociada), 32'(i));
    end
    check_val("full.ocup_drained", 32'(Ocupacion), 32'd0);
    check_val("full.error", 32'(ErrorFlag), 32'd0);
    check_val("full.overrun_late", 32'(Overrun), 32'd1);

    // Desync and overflow
    host_read(9'h004);
    host_read(9'h008);
    result(24'h123456, 1'b0);
    check_val("desync.error",   32'(ErrorFlag), 32'd1);
    check_val("desync.entrada", 32'(EntradaAsociada), 32'h4);
    check_val("desync.salida",  32'(DatoSalida), 32'h123456);
    check_val("desync.ocup",    32'(Ocupacion), 32'd0);
    host_read(9'h00C);
    check_val("other_addr.flags", {30'h0, DatoListo, ErrorFlag}, 32'h3);
    host_read(9'h008);
    check_val("desync.error_clr", 32'(ErrorFlag), 32'd0);
    push(24'hABCDEF);
    result(24'h7FFFFF, 1'b1);
    check_val("ovf.error",   32'(ErrorFlag), 32'd1);
    check_val("ovf.entrada", 32'(EntradaAsociada), 32'hABCDEF);

    // Collisions: clear vs set, push vs pop on a full FIFO
    host_read(9'h004);
    host_read(9'h008);
    push(24'h000007);
    cyc(1'b0, 24'h0, 1'b1, 24'h000070, 1'b0, 1'b1, 9'h004);
    check_val("coll.listo_wins", 32'(DatoListo), 32'd1);
    check_val("coll.entrada7",   32'(EntradaAsociada), 32'h7);
    host_read(9'h004);
    host_read(9'h008);
    for (int i = 0; i < 4; i++) push(24'(32'h21 + i));
    cyc(1'b1, 24'h000025, 1'b1, 24'h000099, 1'b0, 1'b0, 9'h0);
    check_val("coll.ocup_full", 32'(Ocupacion), 32'd4);
    check_val("coll.overrun",   32'(Overrun), 32'd0);
    check_val("coll.entrada21", 32'(EntradaAsociada), 32'h21);
    for (int i = 0; i < 4; i++) begin
      result(24'h0, 1'b0);
      check_val($sformatf("coll.drain%0d", i), 32'(EntradaAsociada), 32'h22 + 32'(i));
    end

    // Reset mid-operation
    host_read(9'h004);
    host_read(9'h008);
    for (int i = 0; i < 4; i++) push(24'(32'h31 + i));
    result(24'h000555, 1'b0);
    check_val("rst.pre_ocup",  32'(Ocupacion), 32'd3);
    check_val("rst.pre_listo", 32'(DatoListo), 32'd1);
    #2 RESET_N = 1'b0;
    #1 check_cleared("rst.async");
    cyc(1'b1, 24'h000AAA, 1'b1, 24'h000BBB, 1'b0, 1'b0, 9'h0);
    check_val("rst.strobe_ignored", {28'h0, DatoListo, Ocupacion}, 32'h0);
    #2 RESET_N = 1'b1;
    result(24'h000666, 1'b0);
    check_val("rst.desync_error", 32'(ErrorFlag), 32'd1);
    check_val("rst.entrada",      32'(EntradaAsociada), 32'h0);
    check_val("rst.salida",       32'(DatoSalida), 32'h000666);
    check_val("rst.ocup",         32'(Ocupacion), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
